// File: rtl/mem_block_reader.sv
// Priority-ordered block reader: walks the non-empty memory blocks from
// block 0 upward and issues one BRAM read per cycle, with no bubbles.
module mem_block_reader #(
  parameter int NBLK  = 20,
  parameter int CNT_W = 6,
  parameter int SEL_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NBLK*CNT_W-1:0] nent,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_W-1:0]      rd_addr,
  output logic                  valid,
  output logic [SEL_W-1:0]      valid_sel,
  output logic                  done
);

  typedef enum logic {IDLE, READ} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NBLK];
  logic [NBLK-1:0]  pending;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] idx;
  logic             fin;

  logic [NBLK-1:0]  start_mask;
  logic [NBLK-1:0]  rem_mask;
  logic [SEL_W-1:0] start_ptr;
  logic [SEL_W-1:0] rem_ptr;
  logic             last_entry;

  function automatic logic [SEL_W-1:0] lowest(input logic [NBLK-1:0] m);
    lowest = '0;
    for (int unsigned i = NBLK; i > 0; i--)
      if (m[i-1]) lowest = SEL_W'(i-1);
  endfunction

  always_comb begin
    start_mask = '0;
    for (int unsigned i = 0; i < NBLK; i++)
      start_mask[i] = (nent[i*CNT_W +: CNT_W] != '0);
    start_ptr     = lowest(start_mask);
    rem_mask      = pending;
    rem_mask[ptr] = 1'b0;
    rem_ptr       = lowest(rem_mask);
    last_entry    = (idx == cnt[ptr] - 1'b1);
  end

  // fin marks "event finished at this edge"; done follows it one cycle
  // later so the pulse lines up with the last valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      ptr       <= '0;
      idx       <= '0;
      fin       <= 1'b0;
      rd_en     <= 1'b0;
      rd_sel    <= '0;
      rd_addr   <= '0;
      valid     <= 1'b0;
      valid_sel <= '0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < NBLK; i++) cnt[i] <= '0;
    end else begin
      valid     <= rd_en;
      valid_sel <= rd_sel;
      done      <= fin;
      fin       <= 1'b0;
      if (start) begin
        for (int unsigned i = 0; i < NBLK; i++) cnt[i] <= nent[i*CNT_W +: CNT_W];
        pending <= start_mask;
        ptr     <= start_ptr;
        idx     <= '0;
        rd_en   <= 1'b0;
        rd_sel  <= '0;
        rd_addr <= '0;
        if (start_mask == '0) begin
          state <= IDLE;
          fin   <= 1'b1;
        end else begin
          state <= READ;
        end
      end else begin
        case (state)
          IDLE: begin
            rd_en   <= 1'b0;
            rd_sel  <= '0;
            rd_addr <= '0;
          end
          READ: begin
            if (stall) begin
              rd_en <= 1'b0;
            end else begin
              rd_en   <= 1'b1;
              rd_sel  <= ptr + 1'b1;
              rd_addr <= idx;
              if (last_entry) begin
                idx     <= '0;
                pending <= rem_mask;
                ptr     <= rem_ptr;
                if (rem_mask == '0) begin
                  state <= IDLE;
                  fin   <= 1'b1;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_block_reader.sv
// Directed and randomized bench for mem_block_reader; expected reads come
// from a flat list of (block+1, entry) pairs built from the counts.
module tb_mem_block_reader;
  localparam int NBLK  = 20;
  localparam int CNT_W = 6;
  localparam int SEL_W = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  stall = 1'b0;
  logic [NBLK*CNT_W-1:0] nent = '0;
  logic                  rd_en;
  logic [SEL_W-1:0]      rd_sel;
  logic [CNT_W-1:0]      rd_addr;
  logic                  valid;
  logic [SEL_W-1:0]      valid_sel;
  logic                  done;

  mem_block_reader #(.NBLK(NBLK), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .nent(nent), .stall(stall),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .valid(valid), .valid_sel(valid_sel), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] addr;
  } rd_t;

  int  tests = 0;
  int  fails = 0;
  int  cnts [NBLK];
  rd_t q [$];
  rd_t last_rd;
  bit  done_next = 0;
  bit  en_prev = 0;
  bit  hold_ok = 0;
  int  prev_sel = 0;
  int  nreads = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_counts();
    for (int i = 0; i < NBLK; i++) nent[i*CNT_W +: CNT_W] = CNT_W'(cnts[i]);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NBLK; i++) cnts[i] = 0;
  endtask

  task automatic scramble_nent();
    for (int i = 0; i < NBLK; i++) nent[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 63));
  endtask

  // One clock: apply inputs, let the edge happen, check against the model.
  task automatic step(input bit st, input bit stl);
    bit exp_en;
    bit exp_done;
    start = st;
    stall = stl;
    @(posedge clk);
    #1;
    exp_en    = 0;
    exp_done  = done_next;
    done_next = 0;
    if (st) begin
      q.delete();
      for (int b = 0; b < NBLK; b++)
        for (int a = 0; a < cnts[b]; a++) q.push_back({SEL_W'(b + 1), CNT_W'(a)});
      if (q.size() == 0) done_next = 1;
      hold_ok = 0;
    end else if (q.size() > 0 && !stl) begin
      exp_en  = 1;
      last_rd = q.pop_front();
      hold_ok = 1;
      nreads++;
      if (q.size() == 0) done_next = 1;
      chk("rd_sel", 32'(rd_sel), 32'(last_rd.sel));
      chk("rd_addr", 32'(rd_addr), 32'(last_rd.addr));
    end else if (q.size() > 0) begin
      if (hold_ok) begin
        chk("hold_sel", 32'(rd_sel), 32'(last_rd.sel));
        chk("hold_addr", 32'(rd_addr), 32'(last_rd.addr));
      end
    end else begin
      chk("idle_sel", 32'(rd_sel), 32'd0);
    end
    chk("rd_en", 32'(rd_en), 32'(exp_en));
    chk("done", 32'(done), 32'(exp_done));
    chk("valid", 32'(valid), 32'(en_prev));
    if (en_prev) chk("valid_sel", 32'(valid_sel), 32'(prev_sel));
    en_prev  = exp_en;
    prev_sel = int'(last_rd.sel);
    start    = 0;
    if (!st) scramble_nent();
  endtask

  // Runs until the model reports the event fully drained and done seen.
  task automatic finish_event(input int stall_pct);
    int guard = 0;
    while ((q.size() > 0 || done_next) && guard < 1000) begin
      step(0, ($urandom_range(0, 99) < stall_pct));
      guard++;
    end
    chk("event_bound", 32'(guard < 1000), 32'd1);
    step(0, 0);
  endtask

  initial begin
    clear_counts();
    last_rd = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_sel", 32'(rd_sel), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #10 reset = 1'b0;
    step(0, 0);
    step(0, 0);

    // all blocks empty: done on the cycle after start, no reads
    set_counts();
    step(1, 0);
    finish_event(0);

    // blocks 0/3/19 with 2/1/3 entries, no stall
    clear_counts();
    cnts[0] = 2; cnts[3] = 1; cnts[19] = 3;
    set_counts();
    nreads = 0;
    step(1, 0);
    finish_event(0);
    chk("reads_a", 32'(nreads), 32'd6);

    // same event, stall for 2 cycles after the 2nd read
    set_counts();
    nreads = 0;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    finish_event(0);
    chk("reads_b", 32'(nreads), 32'd6);

    // full-depth block 5
    clear_counts();
    cnts[5] = 63;
    set_counts();
    nreads = 0;
    step(1, 0);
    finish_event(0);
    chk("reads_63", 32'(nreads), 32'd63);

    // abort event A after its 4th read with event B
    clear_counts();
    cnts[0] = 10;
    set_counts();
    step(1, 0);
    for (int i = 0; i < 4; i++) step(0, 0);
    clear_counts();
    cnts[2] = 1;
    set_counts();
    step(1, 0);
    finish_event(0);

    // randomized events with random stall and mid-event nent churn
    for (int e = 0; e < 12; e++) begin
      for (int i = 0; i < NBLK; i++)
        cnts[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
      set_counts();
      step(1, 0);
      finish_event(30);
    end

    // asynchronous reset in the middle of an event
    clear_counts();
    cnts[1] = 9;
    set_counts();
    step(1, 0);
    step(0, 0);
    step(0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_rd_sel", 32'(rd_sel), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_valid_sel", 32'(valid_sel), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #3 reset = 1'b0;
    q.delete();
    done_next = 0;
    en_prev   = 0;
    hold_ok   = 0;
    for (int i = 0; i < 4; i++) step(0, 0);
    cnts[1] = 3;
    set_counts();
    step(1, 0);
    finish_event(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_block_reader.md
Name: mem_block_reader

Overview:
- Read-side counterpart of the registered block priority encoder.
- Walks a set of NBLK memory blocks in priority order (block 00 first), using each block's entry count for the event.
- Skips empty blocks with no idle cycle and issues one read per cycle: a binary block select plus an entry address.
- Sits between the per-block memories and the stage that consumes the merged stream; drives BRAM read ports with 1-cycle read latency.

Parameters:
- NBLK, 20, number of memory blocks scanned.
- CNT_W, 6, width of each entry count and of the entry address (max 63 entries/block).
- SEL_W, 5, width of the binary block select.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that latches the counts and begins a new event.
- nent  input  NBLK*CNT_W  packed entry counts; block i occupies bits [i*CNT_W +: CNT_W].
- stall  input  1  downstream backpressure; no read is issued in a cycle while high.
- rd_en  output  1  registered read strobe to the memories.
- rd_sel  output  SEL_W  registered block select, encoded as block index + 1 (1..NBLK); 0 when idle.
- rd_addr  output  CNT_W  registered entry address inside the selected block.
- valid  output  1  rd_en delayed 1 cycle, aligned with the memory data.
- valid_sel  output  SEL_W  rd_sel delayed 1 cycle, used as the final mux select.
- done  output  1  one-cycle pulse marking the end of the event.

Behaviour:
- Reset (async assert): state IDLE, pending mask 0, all outputs 0.
- States:
  - IDLE: wait for start.
  - READ: issue reads.
- Start handling (edge E0 samples start=1, in any state):
  - Latch all counts.
  - pending[i] = (nent_i != 0).
  - Block pointer = lowest set bit of pending; entry index = 0.
  - Go to READ, or go to IDLE with done=1 at E1 if pending == 0.
- Start has priority over everything. A start during READ aborts the current event:
  - No done is issued for the aborted event.
  - Reads already issued still produce valid one cycle later.
  - New reads begin at E1.
- READ, per edge with stall=0: rd_en=1, rd_sel=ptr+1, rd_addr=index.
  - If index == count[ptr]-1: clear pending[ptr], reset index to 0, move ptr to the lowest set bit of the remaining mask. The next read comes on the very next edge (no bubble).
  - Otherwise index increments.
- READ, per edge with stall=1: rd_en=0. rd_sel and rd_addr hold their values. Pointer, index and mask are unchanged.
- End of event: when the final entry of the final pending block is issued at edge Ek:
  - State returns to IDLE.
  - At Ek+1: rd_en=0, rd_sel=0, and done=1 coincides with the last valid.
- Throughput: total rd_en cycles per event = sum of the counts; first read at E1 after the start edge E0.
- Priority: a lower block index is always read fully before any higher one. Blocks with count 0 never appear on rd_sel.
- Counts are captured only at start; changes to nent mid-event are ignored.
- done is never asserted in the same cycle as rd_en.

Test Plan:
- Counts all 0, start pulse -> done=1 exactly one cycle after start; rd_en never high; valid never high.
- Counts blk00=2, blk03=1, blk19=3, all others 0 -> rd_sel/rd_addr sequence is (1,0)(1,1)(4,0)(20,0)(20,1)(20,2) on 6 consecutive cycles; done coincides with the 6th valid.
- Same event with stall high for 2 cycles after the 2nd read -> no rd_en during the stall, outputs held at (1,1), sequence resumes at (4,0); total of 6 reads.
- blk05=63, others 0 -> 63 reads with rd_sel=6 and rd_addr 0..62; pointer wraps cleanly to IDLE; done pulse after the last read.
- Event A with blk00=10; start for event B (blk02=1) on A's 4th read -> no done for A; next read is (3,0); done one cycle after that read.
- reset asserted mid-event (asynchronously, between edges) -> all outputs drop to 0 immediately; after release the block stays idle until the next start.
